fb_port_arbiter: RTL and testbench

Shares one single-port 320x240 RGB565 frame-buffer RAM between two requesters: the VGA display prefetch reader and the camera pixel writer.
- VGA reads have strict priority and a fixed 2-cycle address-to-data latency, which matches the display controller's PREFETCH=2.
- Camera writes are buffered in a small FIFO and drained into idle RAM cycles, i.e. outside the 320-cycle read window of each line.
- Sits between the VGA timing block, the camera capture block and the frame-buffer RAM.

---
 rtl/fb_port_arbiter_if.sv | 30 +++
 rtl/fb_port_arbiter.sv | 117 +++++++++++
 tb/tb_fb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: VGA read, camera write and frame-buffer RAM signals of fb_port_arbiter.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int LVL_W  = 4
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_flush;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              busy;
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_flush, mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata, fifo_level, busy
  );
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_flush, mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata, fifo_level, busy
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port frame-buffer sharing, VGA reads first, camera writes via FIFO.
// Define FB_ARB_STATS_EN to add drop_cnt / max_level statistics outputs.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FB_PIXELS  = 76800,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input logic CLK25,
  input logic rst_n,
  fb_port_arbiter_if.slave bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]      drop_cnt,
  output logic [LVL_W-1:0] max_level
`endif
);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(FB_PIXELS);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
  typedef enum logic [1:0] {G_IDLE, G_RD, G_WR} grant_t;
  grant_t r_grant, w_grant_nx;
  logic [ADDR_W+DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [LVL_W-1:0] r_level, w_level_nx;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx, w_head_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nx, w_head_data;
  logic r_mem_we, w_mem_we_nx;
  logic r_rdy, r_oor1, r_oor2, r_rd_valid;
  logic w_push, w_pop, w_full, w_head_oor;

  assign w_full = r_level == LVL_FULL;
  assign {w_head_addr, w_head_data} = r_fifo[r_rp];
  assign w_head_oor = w_head_addr >= ADDR_LIM;
  assign w_push = bus.wr_valid & bus.wr_ready & !bus.wr_flush;
  assign w_pop = !bus.rd_req & (r_level != '0) & !bus.wr_flush;
  assign w_level_nx = bus.wr_flush ? '0 : r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign bus.wr_ready   = r_rdy & !w_full;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = (r_rd_valid & !r_oor2) ? bus.mem_rdata : '0;
  assign bus.fifo_level = r_level;
  assign bus.busy       = (r_level != '0) | r_mem_we;

  // Reads always win; out-of-range write pops still consume the slot but never assert mem_we.
  always_comb begin
    w_grant_nx     = G_IDLE;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_mem_we_nx    = 1'b0;
    if (bus.rd_req) begin
      w_grant_nx    = G_RD;
      w_mem_addr_nx = bus.rd_addr;
    end else if (w_pop) begin
      w_grant_nx     = G_WR;
      w_mem_addr_nx  = w_head_addr;
      w_mem_wdata_nx = w_head_data;
      w_mem_we_nx    = !w_head_oor;
    end
  end

  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= G_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_oor1      <= 1'b0;
      r_oor2      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rdy       <= 1'b0;
      r_level     <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
    end else begin
      r_grant     <= w_grant_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_mem_we    <= w_mem_we_nx;
      r_oor1      <= bus.rd_addr >= ADDR_LIM;
      r_oor2      <= r_oor1;
      r_rd_valid  <= r_grant == G_RD;
      r_rdy       <= 1'b1;
      r_level     <= w_level_nx;
      r_wp        <= bus.wr_flush ? '0 : r_wp + PTR_W'(w_push);
      r_rp        <= bus.wr_flush ? '0 : r_rp + PTR_W'(w_pop);
    end
  end

  always_ff @(posedge CLK25) begin
    if (w_push) r_fifo[r_wp] <= {bus.wr_addr, bus.wr_data};
  end

`ifdef FB_ARB_STATS_EN
  logic [1:0]       w_drop_inc;
  logic [16:0]      w_drop_sum;
  logic [15:0]      r_drop_cnt;
  logic [LVL_W-1:0] r_max_level;
  assign w_drop_inc = 2'(w_pop & w_head_oor) + 2'(bus.wr_valid & !bus.wr_ready);
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
  assign drop_cnt   = r_drop_cnt;
  assign max_level  = r_max_level;
  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt  <= '0;
      r_max_level <= '0;
    end else begin
      r_drop_cnt  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_max_level <= (w_level_nx > r_max_level) ? w_level_nx : r_max_level;
    end
  end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: vector table, directed sequences and random traffic against a queue-based model.
module tb_fb_port_arbiter;
  localparam int FB = 76800;
  localparam int DEPTH = 8;

  logic CLK25 = 1'b0;
  logic rst_n = 1'b0;
  always #20 CLK25 = ~CLK25;

  fb_port_arbiter_if #(.ADDR_W(17), .DATA_W(16), .LVL_W(4)) bus ();

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt;
  logic [3:0]  max_level;
  fb_port_arbiter dut (.CLK25(CLK25), .rst_n(rst_n), .bus(bus), .drop_cnt(drop_cnt), .max_level(max_level));
`else
  fb_port_arbiter dut (.CLK25(CLK25), .rst_n(rst_n), .bus(bus));
`endif

  typedef struct packed {logic [16:0] a; logic [15:0] d;} ent_t;

  // RAM behavioural model with a log of every issued write
  logic [15:0] ram [FB];
  ent_t wlog[$];
  always @(posedge CLK25) begin
    if (bus.mem_we) begin
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
      if (int'(bus.mem_addr) < FB) ram[bus.mem_addr] = bus.mem_wdata;
    end
    bus.mem_rdata <= (int'(bus.mem_addr) < FB) ? ram[bus.mem_addr] : 16'hBEEF;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue, read results from a shadow memory
  logic [15:0] ref_ram [FB];
  ent_t mq[$];
  logic m_rdy, m_we, m_p1v, m_rv;
  logic [16:0] m_addr, m_p1a;
  logic [15:0] m_wdata, m_rd;
  int m_drop, m_max;

  task automatic model_reset();
    mq.delete();
    m_rdy = 0; m_we = 0; m_p1v = 0; m_rv = 0;
    m_addr = 0; m_p1a = 0; m_wdata = 0; m_rd = 0;
    m_drop = 0; m_max = 0;
  endtask

  task automatic model_edge();
    bit rdy, push, pop;
    ent_t h;
    if (m_we) ref_ram[m_addr] = m_wdata;
    m_rv = m_p1v;
    m_rd = (m_p1v && int'(m_p1a) < FB) ? ref_ram[m_p1a] : 16'h0;
    m_p1v = bus.rd_req;
    m_p1a = bus.rd_addr;
    rdy = m_rdy && mq.size() < DEPTH;
    push = bus.wr_valid && rdy && !bus.wr_flush;
    pop = !bus.rd_req && mq.size() > 0 && !bus.wr_flush;
    if (bus.wr_valid && !rdy) m_drop++;
    m_we = 0;
    if (bus.rd_req) m_addr = bus.rd_addr;
    else if (pop) begin
      h = mq.pop_front();
      m_addr = h.a;
      m_wdata = h.d;
      m_we = int'(h.a) < FB;
      if (int'(h.a) >= FB) m_drop++;
    end
    if (bus.wr_flush) mq.delete();
    else if (push) mq.push_back({bus.wr_addr, bus.wr_data});
    if (m_drop > 65535) m_drop = 65535;
    if (mq.size() > m_max) m_max = mq.size();
    m_rdy = 1;
  endtask

  task automatic model_check();
    chk("m_mem_addr", bus.mem_addr, m_addr);
    chk("m_mem_we", bus.mem_we, m_we);
    chk("m_mem_wdata", bus.mem_wdata, m_wdata);
    chk("m_rd_valid", bus.rd_valid, m_rv);
    chk("m_rd_data", bus.rd_data, m_rd);
    chk("m_fifo_level", bus.fifo_level, mq.size());
    chk("m_wr_ready", bus.wr_ready, m_rdy && mq.size() < DEPTH);
    chk("m_busy", bus.busy, mq.size() != 0 || m_we);
`ifdef FB_ARB_STATS_EN
    chk("m_drop_cnt", drop_cnt, m_drop);
    chk("m_max_level", max_level, m_max);
`endif
  endtask

  task automatic step();
    @(posedge CLK25);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input bit rq, input int ra, input bit wv, input int wa, input int wd, input bit fl);
    bus.rd_req = rq;
    bus.rd_addr = 17'(ra);
    bus.wr_valid = wv;
    bus.wr_addr = 17'(wa);
    bus.wr_data = 16'(wd);
    bus.wr_flush = fl;
  endtask

  typedef struct {
    int rq, ra, wv, wa, wd, fl;
    int lvl, rdy, we, ma, rv, rd;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int nxt, nrv, first, last, cnt;
    int wa_s[8];
    int wd_s[8];
    tbl[0]  = '{0, 0,     1, 1000,  'h1111, 0, 1, 1, 0, 0,     0, 0};
    tbl[1]  = '{1, 5,     0, 0,     0,      0, 1, 1, 0, 5,     0, 0};
    tbl[2]  = '{0, 0,     0, 0,     0,      0, 0, 1, 1, 1000,  1, 5};
    tbl[3]  = '{0, 0,     1, 76800, 'h2222, 0, 1, 1, 0, 1000,  0, 0};
    tbl[4]  = '{0, 0,     0, 0,     0,      0, 0, 1, 0, 76800, 0, 0};
    tbl[5]  = '{1, 76800, 0, 0,     0,      0, 0, 1, 0, 76800, 0, 0};
    tbl[6]  = '{1, 7,     0, 0,     0,      0, 0, 1, 0, 7,     1, 0};
    tbl[7]  = '{0, 0,     0, 0,     0,      0, 0, 1, 0, 7,     1, 7};
    tbl[8]  = '{0, 0,     0, 0,     0,      0, 0, 1, 0, 7,     0, 0};
    tbl[9]  = '{1, 9,     1, 20,    'h3333, 0, 1, 1, 0, 9,     0, 0};
    tbl[10] = '{0, 0,     1, 21,    'h4444, 1, 0, 1, 0, 9,     1, 9};
    tbl[11] = '{0, 0,     0, 0,     0,      0, 0, 1, 0, 9,     0, 0};
    for (int i = 0; i < FB; i++) begin
      ram[i] = 16'(i);
      ref_ram[i] = 16'(i);
    end

    // reset held with a write request pending
    drive(0, 0, 1, 50, 'h5555, 0);
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge CLK25);
    #1;
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_fifo_level", bus.fifo_level, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1;
    step();
    chk("rel_wr_ready", bus.wr_ready, 1);
    chk("rel_fifo_level", bus.fifo_level, 0);
    chk("rel_mem_we", bus.mem_we, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // vector table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rq != 0, tbl[i].ra, tbl[i].wv != 0, tbl[i].wa, tbl[i].wd, tbl[i].fl != 0);
      step();
      chk($sformatf("vec%0d_level", i), bus.fifo_level, tbl[i].lvl);
      chk($sformatf("vec%0d_ready", i), bus.wr_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_we", i), bus.mem_we, tbl[i].we);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].ma);
      chk($sformatf("vec%0d_rv", i), bus.rd_valid, tbl[i].rv);
      chk($sformatf("vec%0d_rd", i), bus.rd_data, tbl[i].rd);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // one full line of reads
    nxt = 0; nrv = 0; cnt = 0;
    for (int c = 0; c < 324; c++) begin
      if (c < 320) drive(1, c, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      step();
      if (bus.mem_we) cnt++;
      if (bus.rd_valid) begin
        if (nrv == 0) chk("line_first_valid_cycle", c, 1);
        chk("line_rd_data", bus.rd_data, nxt);
        nxt++;
        nrv++;
      end
    end
    chk("line_valid_count", nrv, 320);
    chk("line_no_we", cnt, 0);

    // fill FIFO under continuous reads, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 1, 100 + i, 'hA000 + i, 0);
      step();
    end
    chk("fill_wr_ready", bus.wr_ready, 0);
    chk("fill_level", bus.fifo_level, 8);
    drive(0, 0, 0, 0, 0, 0);
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.mem_we) begin
        if (first < 0) first = c;
        last = c;
        if (cnt < 8) begin
          wa_s[cnt] = int'(bus.mem_addr);
          wd_s[cnt] = int'(bus.mem_wdata);
        end
        cnt++;
      end
    end
    chk("drain_count", cnt, 8);
    chk("drain_consecutive", last - first, 7);
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", wa_s[i], 100 + i);
      chk("drain_data", wd_s[i], 'hA000 + i);
    end
    chk("drain_level", bus.fifo_level, 0);
    chk("drain_busy", bus.busy, 0);

    // full FIFO with writes held off
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 300 + i, 'hB000 + i, 0);
      step();
    end
`ifdef FB_ARB_STATS_EN
    cnt = int'(drop_cnt);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 999, 'hFFFF, 0);
      step();
      chk("full_wr_ready", bus.wr_ready, 0);
      chk("full_level", bus.fifo_level, 8);
    end
`ifdef FB_ARB_STATS_EN
    chk("full_drop_cnt", drop_cnt, cnt + 5);
`endif
    drive(0, 0, 0, 0, 0, 0);
    wlog.delete();
    repeat (12) step();
    chk("full_wlog_size", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("full_wlog_addr", wlog[i].a, 300 + i);
      chk("full_wlog_data", wlog[i].d, 'hB000 + i);
    end

    // flush with one write already issued
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 200 + i, 'hC000 + i, 0);
      step();
    end
    chk("fl_level5", bus.fifo_level, 5);
    wlog.delete();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("fl_issued_we", bus.mem_we, 1);
    drive(0, 0, 1, 299, 'hDDDD, 1);
    step();
    chk("fl_level0", bus.fifo_level, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();
    chk("fl_wlog_size", wlog.size(), 1);
    if (wlog.size() > 0) chk("fl_wlog_addr", wlog[0].a, 200);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int rq_pct;
      rq_pct = ((c / 100) % 2 == 0) ? 80 : 20;
      drive($urandom_range(0, 99) < rq_pct,
            ($urandom_range(0, 9) == 0) ? FB + $urandom_range(0, 7) : $urandom_range(0, FB - 1),
            $urandom_range(0, 99) < 60,
            ($urandom_range(0, 9) == 0) ? FB + $urandom_range(0, 7) : $urandom_range(0, FB - 1),
            $urandom_range(0, 65535),
            $urandom_range(0, 49) == 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (12) step();
    chk("end_level", bus.fifo_level, 0);
    chk("end_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
